iomem_gpio: RTL

//  Parametrised GPIO peripheral on the PicoSoC iomem bus; successor to the fixed 32-bit LED register in the board tops.

---
 rtl/iomem_gpio.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/iomem_gpio.sv
`default_nettype none
// ============================================================================
//  Module   : iomem_gpio
//  Purpose  : GPIO peripheral on the PicoSoC iomem bus. Per-pin output data,
//             direction, synchronised inputs and per-pin edge interrupts with
//             write-1-to-clear status. Decodes one 16 MB iomem window.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1      system clock
//    resetn       in   1      asynchronous active-low reset
//    iomem_valid  in   1      bus request, held until iomem_ready
//    iomem_ready  out  1      one-cycle acknowledge
//    iomem_wstrb  in   4      byte write strobes, 0 = read
//    iomem_addr   in   32     byte address
//    iomem_wdata  in   32     write data
//    iomem_rdata  out  32     read data, valid while iomem_ready=1
//    gpio_in      in   WIDTH  asynchronous pad inputs
//    gpio_out     out  WIDTH  pad output data (OUT register)
//    gpio_oe      out  WIDTH  pad output enable (DIR register, 1 = drive)
//    irq          out  1      level interrupt = |(IRQ_STAT & IRQ_EN)
//  Register map (word offset, addr[4:2])
//    0 OUT  1 DIR  2 IN (RO)  3 IRQ_EN  4 EDGE  5 IRQ_STAT (W1C)  6-7 RAZ/WI
// ============================================================================
module iomem_gpio #(
  parameter int         WIDTH       = 8,
  parameter logic [7:0] ADDR_BASE   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] REG_OUT      = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_EDGE     = 3'd4;
  localparam logic [2:0] REG_IRQ_STAT = 3'd5;

  logic             hit;
  logic             wr_en;
  logic [2:0]       sel;
  logic [31:0]      lane_mask;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] irq_en_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] irq_stat_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  logic [WIDTH-1:0] pin_s;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_word;

  // Gating with iomem_ready keeps a held request from being taken twice.
  assign hit   = iomem_valid && !iomem_ready && (iomem_addr[31:24] == ADDR_BASE);
  assign wr_en = hit && (iomem_wstrb != 4'b0000);
  assign sel   = iomem_addr[4:2];

  assign lane_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  // Bits at or above WIDTH simply do not exist, so writes to them vanish.
  assign wmask = lane_mask[WIDTH-1:0];
  assign wbits = iomem_wdata[WIDTH-1:0];

  // Address bits outside the decode and lanes beyond WIDTH are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, lane_mask};

  // --------------------------------------------------------------------------
  // Input synchroniser and edge history
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= pin_s;
    end
  end

  assign pin_s   = sync_q[SYNC_STAGES-1];
  // EDGE bit selects rising (1) or falling (0) per pin.
  assign edge_ev = (edge_q & pin_s & ~prev_q) | (~edge_q & ~pin_s & prev_q);
  assign w1c     = (wr_en && (sel == REG_IRQ_STAT)) ? (wbits & wmask) : '0;

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q      <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      edge_q     <= '0;
      irq_stat_q <= '0;
    end else begin
      if (wr_en) begin
        case (sel)
          REG_OUT:    out_q    <= (out_q    & ~wmask) | (wbits & wmask);
          REG_DIR:    dir_q    <= (dir_q    & ~wmask) | (wbits & wmask);
          REG_IRQ_EN: irq_en_q <= (irq_en_q & ~wmask) | (wbits & wmask);
          REG_EDGE:   edge_q   <= (edge_q   & ~wmask) | (wbits & wmask);
          default: ;
        endcase
      end
      // OR-ing the new events after the clear makes a coincident event win.
      irq_stat_q <= (irq_stat_q & ~w1c) | edge_ev;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux: sees register values from before this access's write
  // --------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    case (sel)
      REG_OUT:      rd_word[WIDTH-1:0] = out_q;
      REG_DIR:      rd_word[WIDTH-1:0] = dir_q;
      REG_IN:       rd_word[WIDTH-1:0] = pin_s;
      REG_IRQ_EN:   rd_word[WIDTH-1:0] = irq_en_q;
      REG_EDGE:     rd_word[WIDTH-1:0] = edge_q;
      REG_IRQ_STAT: rd_word[WIDTH-1:0] = irq_stat_q;
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Bus response
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= hit;
      if (hit) begin
        iomem_rdata <= rd_word;
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(irq_stat_q & irq_en_q);

endmodule
`default_nettype wire
